// File: rtl/serial_ram_arbiter_pkg.sv
// Frame constants and tag type shared by the serial RAM arbiter and its round-robin picker.
package serial_ram_arbiter_pkg;

  localparam int unsigned DEF_PINS          = 4;
  localparam int unsigned DEF_LOG2_CYCLES   = 2;
  localparam int unsigned DEF_RAM_ADDR_BITS = 16;
  localparam int unsigned DEF_N_REQ         = 4;
  localparam int unsigned DEF_LATENCY       = 11;

  localparam int unsigned CYCLES    = 1 << DEF_LOG2_CYCLES;
  localparam int unsigned ADDR_BITS = DEF_PINS * CYCLES;
  localparam int unsigned DATA_BITS = ADDR_BITS;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned ID_BITS = id_width(DEF_N_REQ);

  // Sized for the largest supported requester count (8) so any N_REQ fits.
  localparam int unsigned MAX_ID_BITS = 3;

  typedef struct packed {
    logic                   issued;
    logic [MAX_ID_BITS-1:0] id;
  } tag_t;

endpackage

// File: rtl/serial_ram_arbiter_rr.sv
// Round-robin picker: combinational winner search from the slot after the last winner.
module rr_arbiter
  import serial_ram_arbiter_pkg::*;
#(
  parameter  int unsigned N_REQ = DEF_N_REQ,
  localparam int unsigned IDW   = id_width(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   winner
);

  logic [IDW-1:0] ptr;
  logic           found;
  int unsigned    idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    grant  = '0;
    idx    = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
    if (en && found) grant = N_REQ'(1) << winner;
  end

  // Pointer holds the last winner; reset value makes requester 0 highest priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              ptr <= IDW'(N_REQ - 1);
    else if (en && found)   ptr <= winner;
  end

endmodule

// File: rtl/serial_ram_arbiter.sv
// Shares one time-multiplexed serial RAM port among N_REQ read requesters, one word per frame.
module serial_ram_arbiter
  import serial_ram_arbiter_pkg::*;
#(
  parameter  int unsigned PINS          = DEF_PINS,
  parameter  int unsigned LOG2_CYCLES   = DEF_LOG2_CYCLES,
  parameter  int unsigned RAM_ADDR_BITS = DEF_RAM_ADDR_BITS,
  parameter  int unsigned N_REQ         = DEF_N_REQ,
  parameter  int unsigned LATENCY       = DEF_LATENCY,
  localparam int unsigned NCYC          = 1 << LOG2_CYCLES,
  localparam int unsigned WORD_BITS     = PINS * NCYC,
  localparam int unsigned IDW           = id_width(N_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_REQ-1:0]               req_valid,
  input  logic [N_REQ*RAM_ADDR_BITS-1:0] req_addr,
  output logic [N_REQ-1:0]               req_ready,
  output logic [PINS-1:0]                addr_out,
  input  logic [PINS-1:0]                data_in,
  output logic                           resp_valid,
  output logic [IDW-1:0]                 resp_id,
  output logic [WORD_BITS-1:0]           resp_data
);

  localparam int unsigned DEPTH = LATENCY + NCYC;

  logic [LOG2_CYCLES-1:0]     phase;
  logic                       frame_end;
  logic [IDW-1:0]             win_id;
  logic [WORD_BITS-1:0]       sel_addr;
  logic [WORD_BITS-1:0]       addr_sr;
  logic [WORD_BITS-PINS-1:0]  data_sr;
  logic [WORD_BITS-1:0]       data_next;
  tag_t                       new_tag;
  tag_t                       line [DEPTH];
  tag_t                       done;

  assign frame_end = &phase;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid),
    .en     (frame_end),
    .grant  (req_ready),
    .winner (win_id)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase <= '0;
    else       phase <= phase + 1'b1;
  end

  always_comb begin
    sel_addr = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) sel_addr = WORD_BITS'(req_addr[i*RAM_ADDR_BITS +: RAM_ADDR_BITS]);
    end
  end

  // Idle frames load zero, so addr_out stays 0 for the whole following frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          addr_sr <= '0;
    else if (frame_end) addr_sr <= sel_addr;
    else                addr_sr <= addr_sr >> PINS;
  end

  assign addr_out = addr_sr[PINS-1:0];

  always_comb begin
    new_tag        = '0;
    new_tag.issued = |req_ready;
    new_tag.id     = MAX_ID_BITS'(win_id);
  end

  // One tag per clock; only frame-end slots can be issued, the rest are bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) line[i] <= '0;
    end else begin
      line[0] <= new_tag;
      for (int unsigned i = 1; i < DEPTH; i++) line[i] <= line[i-1];
    end
  end

  assign done      = line[DEPTH-1];
  assign data_next = {data_in, data_sr};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_sr    <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else begin
      data_sr    <= data_next[WORD_BITS-1:PINS];
      resp_valid <= done.issued;
      if (done.issued) begin
        resp_id   <= IDW'(done.id);
        resp_data <= data_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_ram_arbiter.sv
// Randomized self-checking bench with a serial RAM model and a frame-level arbiter reference.
module tb_serial_ram_arbiter;

  localparam int P  = 4;
  localparam int C  = 4;
  localparam int L  = 11;
  localparam int N  = 4;
  localparam int AB = 16;
  localparam int W  = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*AB-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic [P-1:0]    addr_out;
  logic [P-1:0]    data_in;
  logic            resp_valid;
  logic [1:0]      resp_id;
  logic [W-1:0]    resp_data;

  always #5 clk = ~clk;

  serial_ram_arbiter #(
    .PINS(P), .LOG2_CYCLES(2), .RAM_ADDR_BITS(AB), .N_REQ(N), .LATENCY(L)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .addr_out(addr_out), .data_in(data_in),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data)
  );

  typedef struct {
    int          due;
    int          id;
    logic [15:0] data;
  } resp_t;

  logic [15:0] mem  [65536];
  logic [3:0]  hist [4096];
  logic        pend [N];
  logic [15:0] paddr [N];
  resp_t       rq [$];
  logic [15:0] frame_addr;
  int          cyc;
  int          ptr;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    cyc        = 0;
    ptr        = N - 1;
    frame_addr = '0;
    rq.delete();
    for (int i = 0; i < 4096; i++) hist[i] = '0;
  endtask

  // Pins and RAM: the RAM collects a frame's address chunks, answers L cycles after the first.
  task automatic drive();
    int k, a;
    logic [15:0] ra, rd;
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = pend[i];
      req_addr[i*AB +: AB]   = paddr[i];
    end
    if (!reset && cyc >= L) begin
      k       = (cyc - L) % C;
      a       = cyc - L - k;
      ra      = {hist[a+3], hist[a+2], hist[a+1], hist[a]};
      rd      = mem[ra] >> (4 * k);
      data_in = rd[3:0];
    end else begin
      data_in = 4'($urandom);
    end
  endtask

  task automatic step(input int prob);
    int          winner;
    logic [3:0]  exp_ready;
    logic [15:0] exp_chunk;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && $urandom_range(99) < prob) begin
        pend[i]  = 1'b1;
        paddr[i] = 16'($urandom);
      end
    end
    drive();
    @(negedge clk);
    hist[cyc] = addr_out;
    winner    = -1;
    exp_ready = '0;
    if (cyc % C == C - 1) begin
      for (int k = 1; k <= N; k++) begin
        if (winner < 0 && pend[(ptr + k) % N]) winner = (ptr + k) % N;
      end
      if (winner >= 0) exp_ready[winner] = 1'b1;
    end
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    exp_chunk = (frame_addr >> (4 * (cyc % C))) & 16'hF;
    check("addr_out", 32'(addr_out), 32'(exp_chunk));
    if (rq.size() > 0 && rq[0].due == cyc) begin
      check("resp_valid", 32'(resp_valid), 32'd1);
      check("resp_id", 32'(resp_id), 32'(rq[0].id));
      check("resp_data", 32'(resp_data), 32'(rq[0].data));
      void'(rq.pop_front());
    end else begin
      check("resp_valid_idle", 32'(resp_valid), 32'd0);
    end
    if (cyc % C == C - 1) begin
      if (winner >= 0) begin
        ptr = winner;
        rq.push_back('{due: cyc + 1 + L + C, id: winner, data: mem[paddr[winner]]});
        frame_addr   = paddr[winner];
        pend[winner] = 1'b0;
      end else begin
        frame_addr = '0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int ncyc);
    reset = 1'b1;
    drive();
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_addr_out", 32'(addr_out), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_id", 32'(resp_id), 32'd0);
      check("rst_resp_data", 32'(resp_data), 32'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < N; i++) begin
      pend[i]  = 1'b0;
      paddr[i] = '0;
    end
    model_reset();
    drive();
    @(posedge clk);
    #1;

    // Single read from requester 2.
    mem[16'h1234] = 16'hBEEF;
    pend[2]  = 1'b1;
    paddr[2] = 16'h1234;
    do_reset(2);
    repeat (24) step(0);

    // Full contention with continuous re-requests.
    for (int i = 0; i < N; i++) begin
      mem[i]   = 16'h1000 + 16'(i);
      pend[i]  = 1'b1;
      paddr[i] = 16'(i);
    end
    do_reset(1);
    repeat (40) step(100);

    // Idle port.
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    do_reset(1);
    repeat (100) step(0);

    // Late request arriving in phase 0.
    do_reset(1);
    repeat (4) step(0);
    pend[1]  = 1'b1;
    paddr[1] = 16'($urandom);
    repeat (24) step(0);

    // Reset with a read in flight; requester 0 asks again afterwards.
    pend[0]  = 1'b1;
    paddr[0] = 16'h00A5;
    do_reset(1);
    repeat (10) step(0);
    pend[0] = 1'b1;
    do_reset(2);
    repeat (30) step(0);

    // Fairness: requester 3 always asking, requester 0 every other frame.
    do_reset(1);
    for (int f = 0; f < 40; f++) begin
      pend[3] = 1'b1;
      if (f % 2 == 0) pend[0] = 1'b1;
      repeat (C) step(0);
    end
    repeat (24) step(0);

    // Random traffic with a mid-run reset.
    do_reset(1);
    repeat (700) step(30);
    do_reset(2);
    repeat (800) step(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
